// File: rtl/izh_pkg.sv
// Constants and types shared by the Izhikevich neuron-update and synaptic-processing units.
package izh_pkg;

  localparam int unsigned numneurons = 2;
  localparam int unsigned tagbits    = 1;
  localparam int unsigned numwidth   = 16;

  // Reason an enqueue request was turned away, in reporting priority order.
  typedef enum logic [1:0] {
    RejNone,
    RejRange,
    RejDup,
    RejFull
  } rej_e;

endpackage

// File: rtl/tag_ram.sv
// Tag storage for the fired-tag queue: one synchronous write port, one asynchronous read port.
module tag_ram #(
  parameter int unsigned depth    = 2,
  parameter int unsigned width    = 1,
  parameter int unsigned addrbits = 1
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [addrbits-1:0] waddr_i,
  input  logic [width-1:0]    wdata_i,
  input  logic [addrbits-1:0] raddr_i,
  output logic [width-1:0]    rdata_o
);

  logic [width-1:0] mem_q [depth];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fired_tag_fifo.sv
// Queue of neuron tags that fired this timestep; each neuron is admitted at most once per step.
module fired_tag_fifo #(
  parameter int unsigned numneurons = izh_pkg::numneurons,
  parameter int unsigned tagbits    = izh_pkg::tagbits,
  parameter int unsigned depth      = numneurons
) (
  input  logic               clk,
  input  logic               asyn_reset,
  input  logic               step_clear,
  input  logic               req_enq,
  input  logic [tagbits-1:0] enq_tag_in,
  input  logic               req_deq,
  output logic [tagbits-1:0] src_tag_out,
  output logic               fifo_empty,
  output logic               fifo_full,
  output logic [tagbits:0]   count,
  output logic               dup_drop,
  output logic               range_err,
  output logic               overflow,
  output logic               underflow,
  output logic               flush_lost
);
  import izh_pkg::*;

  localparam int unsigned        MapBits  = 1 << tagbits;
  localparam logic [tagbits-1:0] LastPtr  = tagbits'(depth - 1);
  localparam logic [tagbits:0]   DepthCnt = (tagbits + 1)'(depth);

  logic [tagbits-1:0] head_q, head_d, tail_q, tail_d, cur_head, cur_tail;
  logic [tagbits:0]   count_q, count_d, cur_count;
  logic [MapBits-1:0] pending_q, pending_d, cur_pending;
  logic               dup_drop_q, dup_drop_d, range_err_q, range_err_d;
  logic               overflow_q, overflow_d, underflow_q, underflow_d;
  logic               flush_lost_q, flush_lost_d;
  logic               in_range, enq_ok, deq_ok;
  logic [tagbits-1:0] ram_rdata;
  rej_e               rej;

  function automatic logic [tagbits-1:0] ptr_inc(input logic [tagbits-1:0] p);
    return (p == LastPtr) ? '0 : p + tagbits'(1);
  endfunction

  always_comb begin
    // A step boundary is applied first; any enqueue this cycle sees the flushed state.
    cur_head    = step_clear ? '0 : head_q;
    cur_tail    = step_clear ? '0 : tail_q;
    cur_count   = step_clear ? '0 : count_q;
    cur_pending = step_clear ? '0 : pending_q;

    in_range = 32'(enq_tag_in) < numneurons;
    deq_ok   = req_deq && !step_clear && (count_q != '0);

    rej = RejNone;
    if (req_enq) begin
      if (!in_range) begin
        rej = RejRange;
      end else if (cur_pending[enq_tag_in]) begin
        rej = RejDup;
      end else if ((cur_count == DepthCnt) && !deq_ok) begin
        rej = RejFull;
      end
    end
    enq_ok = req_enq && (rej == RejNone);

    head_d = deq_ok ? ptr_inc(cur_head) : cur_head;
    tail_d = enq_ok ? ptr_inc(cur_tail) : cur_tail;

    count_d = cur_count;
    if (enq_ok && !deq_ok) begin
      count_d = cur_count + (tagbits + 1)'(1);
    end else if (!enq_ok && deq_ok) begin
      count_d = cur_count - (tagbits + 1)'(1);
    end

    // Dequeue never releases a pending bit: one fire per neuron per step.
    pending_d = cur_pending;
    if (enq_ok) begin
      pending_d[enq_tag_in] = 1'b1;
    end

    dup_drop_d   = (rej == RejDup);
    range_err_d  = (rej == RejRange);
    overflow_d   = overflow_q | (rej == RejFull);
    underflow_d  = underflow_q | (req_deq && !step_clear && (count_q == '0));
    flush_lost_d = flush_lost_q | (step_clear && (count_q != '0));
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      pending_q    <= '0;
      dup_drop_q   <= 1'b0;
      range_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      flush_lost_q <= 1'b0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      pending_q    <= pending_d;
      dup_drop_q   <= dup_drop_d;
      range_err_q  <= range_err_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      flush_lost_q <= flush_lost_d;
    end
  end

  tag_ram #(
    .depth   (depth),
    .width   (tagbits),
    .addrbits(tagbits)
  ) u_tag_ram (
    .clk    (clk),
    .we_i   (enq_ok),
    .waddr_i(cur_tail),
    .wdata_i(enq_tag_in),
    .raddr_i(head_q),
    .rdata_o(ram_rdata)
  );

  // Storage is never reset, so the head read is masked while empty.
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == DepthCnt);
  assign src_tag_out = fifo_empty ? '0 : ram_rdata;
  assign count       = count_q;
  assign dup_drop    = dup_drop_q;
  assign range_err   = range_err_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign flush_lost  = flush_lost_q;

endmodule

// File: tb/tb_fired_tag_fifo.sv
// Directed bench for fired_tag_fifo across several depth / neuron-count configurations.
module tb_fired_tag_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       asyn_reset = 1'b1;
  logic       step_clear = 1'b0;
  logic       req_enq    = 1'b0;
  logic       req_deq    = 1'b0;
  logic [2:0] tag        = 3'd0;

  int n_vec = 0;
  int n_err = 0;

  // A: numneurons=4 depth=4
  logic [1:0] a_src;
  logic [2:0] a_count;
  logic a_empty, a_full, a_dup, a_rng, a_ovf, a_unf, a_fl;
  // B: numneurons=3 depth=2
  logic [1:0] b_src;
  logic [2:0] b_count;
  logic b_empty, b_full, b_dup, b_rng, b_ovf, b_unf, b_fl;
  // C: numneurons=4 depth=3
  logic [1:0] c_src;
  logic [2:0] c_count;
  logic c_empty, c_full, c_dup, c_rng, c_ovf, c_unf, c_fl;
  // E: numneurons=8 depth=4
  logic [2:0] e_src;
  logic [3:0] e_count;
  logic e_empty, e_full, e_dup, e_rng, e_ovf, e_unf, e_fl;

  fired_tag_fifo #(.numneurons(4), .tagbits(2), .depth(4)) u_a (
    .clk(clk), .asyn_reset(asyn_reset), .step_clear(step_clear), .req_enq(req_enq),
    .enq_tag_in(tag[1:0]), .req_deq(req_deq), .src_tag_out(a_src), .fifo_empty(a_empty),
    .fifo_full(a_full), .count(a_count), .dup_drop(a_dup), .range_err(a_rng),
    .overflow(a_ovf), .underflow(a_unf), .flush_lost(a_fl)
  );

  fired_tag_fifo #(.numneurons(3), .tagbits(2), .depth(2)) u_b (
    .clk(clk), .asyn_reset(asyn_reset), .step_clear(step_clear), .req_enq(req_enq),
    .enq_tag_in(tag[1:0]), .req_deq(req_deq), .src_tag_out(b_src), .fifo_empty(b_empty),
    .fifo_full(b_full), .count(b_count), .dup_drop(b_dup), .range_err(b_rng),
    .overflow(b_ovf), .underflow(b_unf), .flush_lost(b_fl)
  );

  fired_tag_fifo #(.numneurons(4), .tagbits(2), .depth(3)) u_c (
    .clk(clk), .asyn_reset(asyn_reset), .step_clear(step_clear), .req_enq(req_enq),
    .enq_tag_in(tag[1:0]), .req_deq(req_deq), .src_tag_out(c_src), .fifo_empty(c_empty),
    .fifo_full(c_full), .count(c_count), .dup_drop(c_dup), .range_err(c_rng),
    .overflow(c_ovf), .underflow(c_unf), .flush_lost(c_fl)
  );

  fired_tag_fifo #(.numneurons(8), .tagbits(3), .depth(4)) u_e (
    .clk(clk), .asyn_reset(asyn_reset), .step_clear(step_clear), .req_enq(req_enq),
    .enq_tag_in(tag), .req_deq(req_deq), .src_tag_out(e_src), .fifo_empty(e_empty),
    .fifo_full(e_full), .count(e_count), .dup_drop(e_dup), .range_err(e_rng),
    .overflow(e_ovf), .underflow(e_unf), .flush_lost(e_fl)
  );

  // One clock with the given request pattern; returns #1 after the edge.
  task automatic cyc(input logic e, input logic [2:0] t, input logic d, input logic c);
    req_enq = e; tag = t; req_deq = d; step_clear = c;
    @(posedge clk); #1;
    req_enq = 1'b0; req_deq = 1'b0; step_clear = 1'b0;
  endtask

  task automatic rst();
    asyn_reset = 1'b1;
    @(posedge clk); #1;
    asyn_reset = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if (a_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", a_count); end
    n_vec++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", a_empty); end
    n_vec++; if (a_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", a_full); end
    n_vec++; if (a_src !== 2'd0) begin n_err++; $display("FAIL reset_src: got %0d want 0", a_src); end
    n_vec++; if ({a_dup, a_rng, a_ovf, a_unf, a_fl} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags: got %b want 00000", {a_dup, a_rng, a_ovf, a_unf, a_fl});
    end
    @(posedge clk); #1;
    asyn_reset = 1'b0;
  endtask

  task automatic test_fifo_order();
    rst();
    cyc(1, 3'd2, 0, 0);
    n_vec++; if (a_count !== 3'd1 || a_src !== 2'd2) begin n_err++; $display("FAIL order_enq1: got cnt %0d src %0d want 1/2", a_count, a_src); end
    cyc(1, 3'd0, 0, 0);
    n_vec++; if (a_count !== 3'd2 || a_src !== 2'd2) begin n_err++; $display("FAIL order_enq2: got cnt %0d src %0d want 2/2", a_count, a_src); end
    cyc(1, 3'd3, 0, 0);
    n_vec++; if (a_count !== 3'd3 || a_src !== 2'd2) begin n_err++; $display("FAIL order_enq3: got cnt %0d src %0d want 3/2", a_count, a_src); end
    cyc(0, 3'd0, 1, 0);
    n_vec++; if (a_count !== 3'd2 || a_src !== 2'd0) begin n_err++; $display("FAIL order_deq1: got cnt %0d src %0d want 2/0", a_count, a_src); end
    cyc(0, 3'd0, 1, 0);
    n_vec++; if (a_count !== 3'd1 || a_src !== 2'd3) begin n_err++; $display("FAIL order_deq2: got cnt %0d src %0d want 1/3", a_count, a_src); end
    cyc(0, 3'd0, 1, 0);
    n_vec++; if (a_count !== 3'd0 || a_empty !== 1'b1 || a_src !== 2'd0) begin
      n_err++; $display("FAIL order_deq3: got cnt %0d empty %b src %0d want 0/1/0", a_count, a_empty, a_src);
    end
  endtask

  task automatic test_dup();
    rst();
    cyc(1, 3'd1, 0, 0);
    cyc(1, 3'd1, 0, 0);
    n_vec++; if (a_dup !== 1'b1 || a_count !== 3'd1) begin n_err++; $display("FAIL dup_pulse: got dup %b cnt %0d want 1/1", a_dup, a_count); end
    cyc(0, 3'd0, 0, 0);
    n_vec++; if (a_dup !== 1'b0) begin n_err++; $display("FAIL dup_one_cycle: got %b want 0", a_dup); end
    cyc(0, 3'd0, 0, 1);
    n_vec++; if (a_count !== 3'd0 || a_fl !== 1'b1) begin n_err++; $display("FAIL dup_clear: got cnt %0d fl %b want 0/1", a_count, a_fl); end
    cyc(1, 3'd1, 0, 0);
    n_vec++; if (a_count !== 3'd1 || a_src !== 2'd1) begin n_err++; $display("FAIL dup_after_clear: got cnt %0d src %0d want 1/1", a_count, a_src); end
  endtask

  task automatic test_flush();
    rst();
    for (int i = 0; i < 4; i++) cyc(1, 3'(i), 0, 0);
    n_vec++; if (a_full !== 1'b1 || a_count !== 3'd4) begin n_err++; $display("FAIL flush_fill: got full %b cnt %0d want 1/4", a_full, a_count); end
    cyc(1, 3'd0, 0, 1);
    n_vec++; if (a_count !== 3'd1 || a_src !== 2'd0 || a_full !== 1'b0 || a_fl !== 1'b1) begin
      n_err++; $display("FAIL flush_clear_enq: got cnt %0d src %0d full %b fl %b want 1/0/0/1", a_count, a_src, a_full, a_fl);
    end
    for (int i = 1; i < 4; i++) cyc(1, 3'(i), 0, 0);
    cyc(1, 3'd0, 0, 0);
    n_vec++; if (a_dup !== 1'b1 || a_ovf !== 1'b0 || a_count !== 3'd4) begin
      n_err++; $display("FAIL flush_fifth: got dup %b ovf %b cnt %0d want 1/0/4", a_dup, a_ovf, a_count);
    end
  endtask

  task automatic test_overflow_range();
    rst();
    cyc(1, 3'd0, 0, 0);
    cyc(1, 3'd1, 0, 0);
    n_vec++; if (b_full !== 1'b1 || b_count !== 3'd2) begin n_err++; $display("FAIL ovf_fill: got full %b cnt %0d want 1/2", b_full, b_count); end
    cyc(1, 3'd2, 0, 0);
    n_vec++; if (b_ovf !== 1'b1 || b_dup !== 1'b0 || b_count !== 3'd2) begin
      n_err++; $display("FAIL ovf_third: got ovf %b dup %b cnt %0d want 1/0/2", b_ovf, b_dup, b_count);
    end
    cyc(1, 3'd3, 0, 0);
    n_vec++; if (b_rng !== 1'b1 || b_count !== 3'd2) begin n_err++; $display("FAIL range_pulse: got rng %b cnt %0d want 1/2", b_rng, b_count); end
    cyc(0, 3'd0, 0, 0);
    n_vec++; if (b_rng !== 1'b0 || b_ovf !== 1'b1) begin n_err++; $display("FAIL range_sticky: got rng %b ovf %b want 0/1", b_rng, b_ovf); end
  endtask

  task automatic test_back_to_back();
    rst();
    cyc(1, 3'd3, 0, 0); cyc(1, 3'd2, 0, 0); cyc(1, 3'd1, 0, 0); cyc(1, 3'd0, 0, 0);
    n_vec++; if (e_full !== 1'b1) begin n_err++; $display("FAIL b2b_full: got %b want 1", e_full); end
    cyc(1, 3'd5, 1, 0);
    n_vec++; if (e_count !== 4'd4 || e_src !== 3'd2 || e_full !== 1'b1) begin
      n_err++; $display("FAIL b2b_at_full: got cnt %0d src %0d full %b want 4/2/1", e_count, e_src, e_full);
    end
    cyc(0, 3'd0, 1, 0);
    n_vec++; if (e_src !== 3'd1) begin n_err++; $display("FAIL b2b_deq1: got %0d want 1", e_src); end
    cyc(0, 3'd0, 1, 0);
    n_vec++; if (e_src !== 3'd0) begin n_err++; $display("FAIL b2b_deq2: got %0d want 0", e_src); end
    cyc(0, 3'd0, 1, 0);
    n_vec++; if (e_src !== 3'd5 || e_count !== 4'd1) begin n_err++; $display("FAIL b2b_deq3: got src %0d cnt %0d want 5/1", e_src, e_count); end
    cyc(0, 3'd0, 1, 0);
    n_vec++; if (e_count !== 4'd0) begin n_err++; $display("FAIL b2b_drain: got %0d want 0", e_count); end
    cyc(1, 3'd4, 0, 0);
    cyc(1, 3'd6, 1, 0);
    n_vec++; if (e_count !== 4'd1 || e_src !== 3'd6) begin n_err++; $display("FAIL b2b_at_one: got cnt %0d src %0d want 1/6", e_count, e_src); end

    rst();
    cyc(1, 3'd0, 0, 0); cyc(1, 3'd1, 0, 0); cyc(1, 3'd2, 0, 0);
    n_vec++; if (c_full !== 1'b1) begin n_err++; $display("FAIL wrap_full: got %b want 1", c_full); end
    cyc(1, 3'd3, 1, 0);
    n_vec++; if (c_count !== 3'd3 || c_src !== 2'd1) begin n_err++; $display("FAIL wrap_swap: got cnt %0d src %0d want 3/1", c_count, c_src); end
    cyc(0, 3'd0, 1, 0);
    n_vec++; if (c_src !== 2'd2) begin n_err++; $display("FAIL wrap_deq1: got %0d want 2", c_src); end
    cyc(0, 3'd0, 1, 0);
    n_vec++; if (c_src !== 2'd3 || c_count !== 3'd1) begin n_err++; $display("FAIL wrap_deq2: got src %0d cnt %0d want 3/1", c_src, c_count); end
    cyc(0, 3'd0, 1, 0);
    n_vec++; if (c_empty !== 1'b1) begin n_err++; $display("FAIL wrap_empty: got %b want 1", c_empty); end
  endtask

  task automatic test_underflow();
    rst();
    cyc(0, 3'd0, 1, 0);
    n_vec++; if (a_unf !== 1'b1 || a_count !== 3'd0 || a_empty !== 1'b1) begin
      n_err++; $display("FAIL unf_empty: got unf %b cnt %0d empty %b want 1/0/1", a_unf, a_count, a_empty);
    end
    rst();
    cyc(1, 3'd2, 1, 0);
    n_vec++; if (a_unf !== 1'b1 || a_count !== 3'd1 || a_src !== 2'd2) begin
      n_err++; $display("FAIL unf_enq_deq: got unf %b cnt %0d src %0d want 1/1/2", a_unf, a_count, a_src);
    end
    rst();
    cyc(1, 3'd1, 0, 0);
    cyc(0, 3'd0, 1, 1);
    n_vec++; if (a_unf !== 1'b0 || a_count !== 3'd0 || a_fl !== 1'b1) begin
      n_err++; $display("FAIL unf_clear_deq: got unf %b cnt %0d fl %b want 0/0/1", a_unf, a_count, a_fl);
    end
  endtask

  task automatic test_mid_reset();
    rst();
    cyc(1, 3'd1, 0, 0);
    cyc(1, 3'd2, 0, 0);
    n_vec++; if (a_count !== 3'd2) begin n_err++; $display("FAIL mid_pre: got %0d want 2", a_count); end
    asyn_reset = 1'b1;
    #1;
    n_vec++; if (a_count !== 3'd0 || a_empty !== 1'b1 || a_src !== 2'd0) begin
      n_err++; $display("FAIL mid_async: got cnt %0d empty %b src %0d want 0/1/0", a_count, a_empty, a_src);
    end
    @(posedge clk); #1;
    asyn_reset = 1'b0;
    cyc(1, 3'd2, 0, 0);
    n_vec++; if (a_count !== 3'd1 || a_src !== 2'd2 || a_dup !== 1'b0) begin
      n_err++; $display("FAIL mid_post: got cnt %0d src %0d dup %b want 1/2/0", a_count, a_src, a_dup);
    end
  endtask

  initial begin
    test_reset();
    test_fifo_order();
    test_dup();
    test_flush();
    test_overflow_range();
    test_back_to_back();
    test_underflow();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
